// File: rtl/serial_adder_if.sv
// Serial adder request/result bundle.
// The sub signal exists only when SERIAL_ADDER_SUB_EN is defined.
interface serial_adder_if #(
  parameter int unsigned WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
`ifdef SERIAL_ADDER_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

`ifdef SERIAL_ADDER_SUB_EN
  modport master (output start, a, b, cin, sub, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, sub, output busy, done, sum, cout, ovf);
`else
  modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
  modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`endif
endinterface

// File: rtl/serial_adder.sv
// Digit-serial adder: adds DIGIT bits per clock over WIDTH/DIGIT cycles.
// Optional SERIAL_ADDER_SUB_EN adds a sub input selecting a - b.
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 1
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus
);
  localparam int unsigned N     = WIDTH / DIGIT;
  localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] acc;
  logic             carry;

  logic [WIDTH-1:0] b_eff;
  logic             c_init;
  logic [DIGIT-1:0] dig_s;
  logic             dig_c;
  logic [WIDTH-1:0] acc_nxt;
  logic             last_dig;
  logic             ovf_nxt;

  // Effective B operand and initial carry for the request being accepted
  always_comb begin
    b_eff  = bus.b;
    c_init = bus.cin;
`ifdef SERIAL_ADDER_SUB_EN
    if (bus.sub) begin
      b_eff  = ~bus.b;
      c_init = 1'b1;
    end
`endif
  end

  // Ripple chain of DIGIT full adders over the low unprocessed digit
  always_comb begin
    logic c;
    c     = carry;
    dig_s = '0;
    for (int i = 0; i < int'(DIGIT); i++) begin
      dig_s[i] = a_r[i] ^ b_r[i] ^ c;
      c        = (a_r[i] & b_r[i]) | (c & (a_r[i] ^ b_r[i]));
    end
    dig_c    = c;
    acc_nxt  = (acc >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    last_dig = (cnt == CNT_W'(N - 1));
    // On the last digit the low bits of a_r/b_r hold the operand MSBs
    ovf_nxt  = (a_r[DIGIT-1] == b_r[DIGIT-1]) && (dig_s[DIGIT-1] != a_r[DIGIT-1]);
  end

  // Control FSM, operand shifters and registered results
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_r      <= '0;
      b_r      <= '0;
      acc      <= '0;
      carry    <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.sum  <= '0;
      bus.cout <= 1'b0;
      bus.ovf  <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            a_r      <= bus.a;
            b_r      <= b_eff;
            carry    <= c_init;
            acc      <= '0;
            cnt      <= '0;
            bus.busy <= 1'b1;
            state    <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          a_r   <= a_r >> DIGIT;
          b_r   <= b_r >> DIGIT;
          acc   <= acc_nxt;
          carry <= dig_c;
          cnt   <= cnt + CNT_W'(1);
          if (last_dig) begin
            bus.sum  <= acc_nxt;
            bus.cout <= dig_c;
            bus.ovf  <= ovf_nxt;
            bus.busy <= 1'b0;
            bus.done <= 1'b1;
            state    <= DONE;
          end
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule
